vga_timing_25: RTL

VGA_TIMING_25 -- requirements
Module: vga_timing_25

---
 rtl/vga_timing_25.sv | 120 ++++++++++++
 1 files changed

// File: rtl/vga_timing_25.sv
// VGA raster timing generator: h/v counters with x/y, sync, active and start pulses.
// Timing flags can be delayed LATENCY enabled cycles behind x/y to match a downstream pixel pipeline.
module vga_timing_25 #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int LATENCY  = 0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       active,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  H_MAX = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_MAX = 10'(V_TOTAL - 1);
  localparam logic [10:0] HA    = 11'(H_ACTIVE);
  localparam logic [10:0] HS0   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS1   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VA    = 11'(V_ACTIVE);
  localparam logic [10:0] VS0   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS1   = 11'(V_ACTIVE + V_FP + V_SYNC);

  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
    logic ls;
    logic fs;
  } tim_t;

  localparam tim_t IDLE = '{hs: ~SYNC_POL, vs: ~SYNC_POL, act: 1'b0, ls: 1'b0, fs: 1'b0};

  logic [9:0]  h_q, h_d;
  logic [9:0]  v_q, v_d;
  logic [10:0] h_ext, v_ext;
  tim_t        raw;
  tim_t        tim;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (enable) begin
      if (h_q == H_MAX) begin
        h_d = '0;
        v_d = (v_q == V_MAX) ? 10'd0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_ext = {1'b0, h_q};
  assign v_ext = {1'b0, v_q};

  // v only moves on an h wrap, so vsync can only change while h is 0.
  always_comb begin
    raw     = IDLE;
    raw.act = (h_ext < HA) && (v_ext < VA);
    raw.hs  = ((h_ext >= HS0) && (h_ext < HS1)) ? SYNC_POL : ~SYNC_POL;
    raw.vs  = ((v_ext >= VS0) && (v_ext < VS1)) ? SYNC_POL : ~SYNC_POL;
    raw.ls  = (h_q == 10'd0);
    raw.fs  = (h_q == 10'd0) && (v_q == 10'd0);
  end

  generate
    if (LATENCY == 0) begin : g_nolat
      // Counters sit at (0,0) during reset, so the flags must be masked until release.
      assign tim = reset_n ? raw : IDLE;
    end else begin : g_pipe
      tim_t pipe_q [LATENCY];

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < LATENCY; i++) pipe_q[i] <= IDLE;
        end else if (enable) begin
          pipe_q[0] <= raw;
          for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end

      assign tim = pipe_q[LATENCY-1];
    end
  endgenerate

  assign x           = h_q;
  assign y           = v_q;
  assign hsync       = tim.hs;
  assign vsync       = tim.vs;
  assign active      = tim.act;
  // Frozen stages would otherwise repeat a start pulse for every stalled cycle.
  assign line_start  = tim.ls & enable;
  assign frame_start = tim.fs & enable;

endmodule
